// File: rtl/i2c_txn_sequencer_if.sv
// rtl/i2c_txn_sequencer_if.sv - request, write-data, command/response and read-data bundle
interface i2c_txn_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_op;
    logic [6:0]            req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_kind;
    logic [DATA_WIDTH-1:0] cmd_byte;
    logic                  cmd_last;
    logic                  rsp_valid;
    logic                  rsp_ack;
    logic [DATA_WIDTH-1:0] rsp_byte;
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done;
    logic                  err_nack;
    logic                  busy;

    modport slave (
        input  req_valid, req_op, req_addr, req_len, wdata_valid, wdata,
               cmd_ready, rsp_valid, rsp_ack, rsp_byte,
        output req_ready, wdata_ready, cmd_valid, cmd_kind, cmd_byte, cmd_last,
               rdata_valid, rdata, done, err_nack, busy
    );

    modport master (
        output req_valid, req_op, req_addr, req_len, wdata_valid, wdata,
               cmd_ready, rsp_valid, rsp_ack, rsp_byte,
        input  req_ready, wdata_ready, cmd_valid, cmd_kind, cmd_byte, cmd_last,
               rdata_valid, rdata, done, err_nack, busy
    );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - turns I2C transactions into START/ADDR/DATA/STOP byte commands
module i2c_txn_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = 4,
    parameter int WDATA_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    i2c_txn_sequencer_if.slave bus
);
    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_DATA  = 2'b10;
    localparam logic [1:0] CMD_ADDR  = 2'b11;
    localparam int AW = $clog2(WDATA_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_WRITE, S_READ, S_STOP} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  op_q;
    logic [6:0]            addr_q;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q, cnt_d, cnt_inc, len_m1;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  err_nack_q, err_nack_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem [WDATA_DEPTH];

    logic fifo_empty, fifo_full, push, pop, flush, accept;
    logic cmd_valid, cmd_fire, rsp_fire;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = bus.wdata_valid && !fifo_full;
    assign wr_ptr_d   = wr_ptr_q + PW'(push);

    // One command in flight: cmd_valid drops after the handshake until its response returns.
    assign cmd_valid = (state_q != S_IDLE) && !pend_q && ((state_q != S_WRITE) || !fifo_empty);
    assign cmd_fire  = cmd_valid && bus.cmd_ready;
    assign rsp_fire  = pend_q && bus.rsp_valid;
    assign pop       = cmd_fire && (state_q == S_WRITE);
    assign cnt_inc   = cnt_q + LEN_WIDTH'(1);
    assign len_m1    = len_q - LEN_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        done_d        = 1'b0;
        err_nack_d    = 1'b0;
        rdata_valid_d = 1'b0;
        rdata_d       = rdata_q;
        flush         = 1'b0;
        accept        = 1'b0;
        if (cmd_fire) pend_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_START: begin
                if (rsp_fire) begin
                    pend_d  = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rsp_fire) begin
                    pend_d = 1'b0;
                    if (!bus.rsp_ack) begin
                        err_d   = 1'b1;
                        state_d = S_STOP;
                    end else if (len_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = op_q ? S_READ : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (rsp_fire) begin
                    pend_d = 1'b0;
                    cnt_d  = cnt_inc;
                    if (!bus.rsp_ack) begin
                        err_d   = 1'b1;
                        state_d = S_STOP;
                    end else if (cnt_inc == len_q) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_READ: begin
                if (rsp_fire) begin
                    pend_d        = 1'b0;
                    cnt_d         = cnt_inc;
                    rdata_d       = bus.rsp_byte;
                    rdata_valid_d = 1'b1;
                    if (cnt_inc == len_q) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rsp_fire) begin
                    pend_d     = 1'b0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    err_nack_d = err_q;
                    flush      = err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= 1'b0;
            op_q          <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            err_nack_q    <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            done_q        <= done_d;
            err_nack_q    <= err_nack_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            wr_ptr_q      <= wr_ptr_d;
            if (accept) begin
                op_q   <= bus.req_op;
                addr_q <= bus.req_addr;
                len_q  <= bus.req_len;
            end
            // An aborted burst leaves its unsent bytes behind; drop everything queued.
            if (flush)    rd_ptr_q <= wr_ptr_d;
            else if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= bus.wdata;
    end

    always_comb begin
        bus.cmd_kind = CMD_START;
        bus.cmd_byte = '0;
        case (state_q)
            S_ADDR: begin
                bus.cmd_kind = CMD_ADDR;
                bus.cmd_byte = DATA_WIDTH'({addr_q, op_q});
            end
            S_WRITE: begin
                bus.cmd_kind = CMD_DATA;
                bus.cmd_byte = mem[rd_ptr_q[AW-1:0]];
            end
            S_READ:  bus.cmd_kind = CMD_DATA;
            S_STOP:  bus.cmd_kind = CMD_STOP;
            default: bus.cmd_kind = CMD_START;
        endcase
    end

    assign bus.cmd_valid   = cmd_valid;
    assign bus.cmd_last    = (state_q == S_READ) && (cnt_q == len_m1);
    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.wdata_ready = !fifo_full;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.err_nack    = err_nack_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - directed self-checking bench for i2c_txn_sequencer
module tb_i2c_txn_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    i2c_txn_sequencer_if #(.DATA_WIDTH(8), .LEN_WIDTH(4)) bus_if ();

    i2c_txn_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .WDATA_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_byte(input logic [7:0] b);
        bus_if.wdata_valid = 1'b1;
        bus_if.wdata       = b;
        @(negedge clk);
        bus_if.wdata_valid = 1'b0;
        bus_if.wdata       = 8'h00;
    endtask

    task automatic issue_req(input logic op, input logic [6:0] addr, input logic [3:0] len);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_addr  = addr;
        bus_if.req_len   = len;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    // Plays the bit controller for one command; reports what was seen, no judging.
    task automatic serve_cmd(input int stall, input logic ack, input logic [7:0] rb,
                             output logic [1:0] kind, output logic [7:0] byt, output logic last,
                             output bit ok, output bit stable);
        int waited;
        waited = 0; ok = 1'b0; stable = 1'b1;
        kind = 2'b00; byt = 8'h00; last = 1'b0;
        while (bus_if.cmd_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus_if.cmd_valid !== 1'b1) return;
        kind = bus_if.cmd_kind; byt = bus_if.cmd_byte; last = bus_if.cmd_last;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus_if.cmd_valid !== 1'b1 || bus_if.cmd_kind !== kind ||
                bus_if.cmd_byte !== byt || bus_if.cmd_last !== last) stable = 1'b0;
        end
        bus_if.cmd_ready = 1'b1;
        @(negedge clk);
        bus_if.cmd_ready = 1'b0;
        if (bus_if.cmd_valid !== 1'b0) stable = 1'b0;
        @(negedge clk);
        if (bus_if.cmd_valid !== 1'b0) stable = 1'b0;
        bus_if.rsp_valid = 1'b1; bus_if.rsp_ack = ack; bus_if.rsp_byte = rb;
        @(negedge clk);
        bus_if.rsp_valid = 1'b0; bus_if.rsp_ack = 1'b0; bus_if.rsp_byte = 8'h00;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus_if.req_ready, bus_if.wdata_ready, bus_if.cmd_valid, bus_if.cmd_kind, bus_if.cmd_byte,
             bus_if.cmd_last, bus_if.rdata_valid, bus_if.rdata, bus_if.done, bus_if.err_nack, bus_if.busy}
            !== {1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: rr=%b wr=%b cv=%b kind=%0d byte=%h last=%b rv=%b rd=%h done=%b err=%b busy=%b, expected rr=1 wr=1 rest 0",
                     bus_if.req_ready, bus_if.wdata_ready, bus_if.cmd_valid, bus_if.cmd_kind, bus_if.cmd_byte,
                     bus_if.cmd_last, bus_if.rdata_valid, bus_if.rdata, bus_if.done, bus_if.err_nack, bus_if.busy);
        end
        bus_if.rsp_valid = 1'b1; bus_if.rsp_ack = 1'b1;
        @(negedge clk);
        bus_if.rsp_valid = 1'b0; bus_if.rsp_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_rsp: busy=%b done=%b, expected 0 0", bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_write_basic();
        logic [1:0] ek [6];
        logic [7:0] eb [6];
        logic [1:0] k; logic [7:0] b; logic l; bit ok, st;
        ek = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01};
        eb = '{8'h00, 8'h44, 8'hA5, 8'h5A, 8'hFF, 8'h00};
        push_byte(8'hA5); push_byte(8'h5A); push_byte(8'hFF);
        issue_req(1'b0, 7'h22, 4'd3);
        n_cmp++;
        if (bus_if.cmd_valid !== 1'b1 || bus_if.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_first_cmd: cmd_valid=%b busy=%b, expected 1 1", bus_if.cmd_valid, bus_if.busy);
        end
        for (int i = 0; i < 6; i++) begin
            serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
            n_cmp++;
            if (!ok || !st || k !== ek[i] || b !== eb[i]) begin
                n_bad++;
                $display("FAIL wr_basic_cmd%0d: kind=%0d byte=%h ok=%0d stable=%0d, expected kind=%0d byte=%h",
                         i, k, b, ok, st, ek[i], eb[i]);
            end
        end
        n_cmp++;
        if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_basic_done: done=%b err=%b, expected 1 0", bus_if.done, bus_if.err_nack);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_if.done !== 1'b0 || bus_if.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL done_pulse: done=%b req_ready=%b, expected 0 1", bus_if.done, bus_if.req_ready);
        end
    endtask

    task automatic test_read_basic();
        logic [1:0] ek [5];
        logic [7:0] eb [5];
        logic       el [5];
        logic [7:0] rb [5];
        logic [1:0] k; logic [7:0] b; logic l; bit ok, st;
        ek = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01};
        eb = '{8'h00, 8'h21, 8'h00, 8'h00, 8'h00};
        el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rb = '{8'h00, 8'h00, 8'h3C, 8'hC3, 8'h00};
        issue_req(1'b1, 7'h10, 4'd2);
        for (int i = 0; i < 5; i++) begin
            serve_cmd(0, 1'b1, rb[i], k, b, l, ok, st);
            n_cmp++;
            if (!ok || !st || k !== ek[i] || b !== eb[i] || l !== el[i]) begin
                n_bad++;
                $display("FAIL rd_basic_cmd%0d: kind=%0d byte=%h last=%b ok=%0d stable=%0d, expected kind=%0d byte=%h last=%b",
                         i, k, b, l, ok, st, ek[i], eb[i], el[i]);
            end
            if (i == 2 || i == 3) begin
                n_cmp++;
                if (bus_if.rdata_valid !== 1'b1 || bus_if.rdata !== rb[i]) begin
                    n_bad++;
                    $display("FAIL rd_basic_rdata%0d: valid=%b rdata=%h, expected 1 %h",
                             i - 2, bus_if.rdata_valid, bus_if.rdata, rb[i]);
                end
            end
        end
        n_cmp++;
        if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b0 || bus_if.rdata_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_basic_done: done=%b err=%b rvalid=%b, expected 1 0 0",
                     bus_if.done, bus_if.err_nack, bus_if.rdata_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_write_nack();
        logic [1:0] ek [5];
        logic [7:0] eb [5];
        logic       ea [5];
        logic [1:0] k; logic [7:0] b; logic l; bit ok, st;
        ek = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01};
        eb = '{8'h00, 8'hA0, 8'h11, 8'h22, 8'h00};
        ea = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        issue_req(1'b0, 7'h50, 4'd4);
        for (int i = 0; i < 5; i++) begin
            serve_cmd(0, ea[i], 8'h00, k, b, l, ok, st);
            n_cmp++;
            if (!ok || !st || k !== ek[i] || b !== eb[i]) begin
                n_bad++;
                $display("FAIL wr_nack_cmd%0d: kind=%0d byte=%h ok=%0d stable=%0d, expected kind=%0d byte=%h",
                         i, k, b, ok, st, ek[i], eb[i]);
            end
        end
        n_cmp++;
        if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_nack_done: done=%b err=%b, expected 1 1", bus_if.done, bus_if.err_nack);
        end
        @(negedge clk);
        // A flushed FIFO means the next write sends only the freshly queued byte.
        ek = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b01};
        eb = '{8'h00, 8'h02, 8'h77, 8'h00, 8'h00};
        push_byte(8'h77);
        issue_req(1'b0, 7'h01, 4'd1);
        for (int i = 0; i < 4; i++) begin
            serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
            n_cmp++;
            if (!ok || k !== ek[i] || b !== eb[i]) begin
                n_bad++;
                $display("FAIL after_flush_cmd%0d: kind=%0d byte=%h ok=%0d, expected kind=%0d byte=%h",
                         i, k, b, ok, ek[i], eb[i]);
            end
        end
        n_cmp++;
        if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b0) begin
            n_bad++;
            $display("FAIL after_flush_done: done=%b err=%b, expected 1 0", bus_if.done, bus_if.err_nack);
        end
        @(negedge clk);
    endtask

    task automatic test_addr_nack();
        logic [1:0] ek [3];
        logic [7:0] eb [3];
        logic [1:0] k; logic [7:0] b; logic l; bit ok, st, saw_rv;
        ek = '{2'b00, 2'b11, 2'b01};
        eb = '{8'h00, 8'h75, 8'h00};
        saw_rv = 1'b0;
        issue_req(1'b1, 7'h3A, 4'd5);
        for (int i = 0; i < 3; i++) begin
            serve_cmd(0, (i == 1) ? 1'b0 : 1'b1, 8'hEE, k, b, l, ok, st);
            if (bus_if.rdata_valid !== 1'b0) saw_rv = 1'b1;
            n_cmp++;
            if (!ok || !st || k !== ek[i] || b !== eb[i]) begin
                n_bad++;
                $display("FAIL addr_nack_cmd%0d: kind=%0d byte=%h ok=%0d stable=%0d, expected kind=%0d byte=%h",
                         i, k, b, ok, st, ek[i], eb[i]);
            end
        end
        n_cmp++;
        if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b1 || saw_rv) begin
            n_bad++;
            $display("FAIL addr_nack_done: done=%b err=%b saw_rdata_valid=%0d, expected 1 1 0",
                     bus_if.done, bus_if.err_nack, saw_rv);
        end
        @(negedge clk);
    endtask

    task automatic test_trickle();
        logic [7:0] data [8];
        data = '{8'h01, 8'h82, 8'h43, 8'hC4, 8'h25, 8'hA6, 8'h67, 8'hE8};
        fork
            begin
                for (int kk = 0; kk < 8; kk++) begin
                    repeat ((kk == 0) ? 20 : 10) @(negedge clk);
                    if (kk > 0) begin
                        n_cmp++;
                        if (bus_if.cmd_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
                            n_bad++;
                            $display("FAIL trickle_empty%0d: cmd_valid=%b busy=%b, expected 0 1",
                                     kk, bus_if.cmd_valid, bus_if.busy);
                        end
                    end
                    push_byte(data[kk]);
                end
            end
            begin
                logic [1:0] k; logic [7:0] b; logic l; bit ok, st;
                logic [1:0] ek; logic [7:0] eb;
                issue_req(1'b0, 7'h2B, 4'd8);
                for (int i = 0; i < 11; i++) begin
                    serve_cmd(3, 1'b1, 8'h00, k, b, l, ok, st);
                    ek = (i == 0) ? 2'b00 : (i == 1) ? 2'b11 : (i == 10) ? 2'b01 : 2'b10;
                    eb = (i == 1) ? 8'h56 : (i >= 2 && i <= 9) ? data[i-2] : 8'h00;
                    n_cmp++;
                    if (!ok || !st || k !== ek || b !== eb) begin
                        n_bad++;
                        $display("FAIL trickle_cmd%0d: kind=%0d byte=%h ok=%0d stable=%0d, expected kind=%0d byte=%h",
                                 i, k, b, ok, st, ek, eb);
                    end
                end
                n_cmp++;
                if (bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b0) begin
                    n_bad++;
                    $display("FAIL trickle_done: done=%b err=%b, expected 1 0", bus_if.done, bus_if.err_nack);
                end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_midread();
        logic [1:0] k; logic [7:0] b; logic l; bit ok, st;
        int waited;
        issue_req(1'b1, 7'h33, 4'd4);
        serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
        serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
        serve_cmd(0, 1'b1, 8'h12, k, b, l, ok, st);
        waited = 0;
        while (bus_if.cmd_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus_if.cmd_valid !== 1'b1 || bus_if.cmd_kind !== 2'b10) begin
            n_bad++;
            $display("FAIL midread_byte2: cmd_valid=%b kind=%0d, expected 1 2", bus_if.cmd_valid, bus_if.cmd_kind);
        end
        bus_if.cmd_ready = 1'b1;
        @(negedge clk);
        bus_if.cmd_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus_if.req_ready, bus_if.wdata_ready, bus_if.cmd_valid, bus_if.cmd_kind, bus_if.rdata_valid,
             bus_if.rdata, bus_if.done, bus_if.err_nack, bus_if.busy}
            !== {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midread_reset: rr=%b wr=%b cv=%b kind=%0d rv=%b rd=%h done=%b err=%b busy=%b, expected rr=1 wr=1 rest 0",
                     bus_if.req_ready, bus_if.wdata_ready, bus_if.cmd_valid, bus_if.cmd_kind, bus_if.rdata_valid,
                     bus_if.rdata, bus_if.done, bus_if.err_nack, bus_if.busy);
        end
        rst = 1'b0;
        @(negedge clk);
        issue_req(1'b1, 7'h05, 4'd1);
        serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
        serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
        n_cmp++;
        if (!ok || k !== 2'b11 || b !== 8'h0B) begin
            n_bad++;
            $display("FAIL post_reset_addr: kind=%0d byte=%h ok=%0d, expected kind=3 byte=0b", k, b, ok);
        end
        serve_cmd(0, 1'b1, 8'h6E, k, b, l, ok, st);
        n_cmp++;
        if (!ok || k !== 2'b10 || l !== 1'b1 || bus_if.rdata_valid !== 1'b1 || bus_if.rdata !== 8'h6E) begin
            n_bad++;
            $display("FAIL post_reset_data: kind=%0d last=%b ok=%0d rv=%b rdata=%h, expected kind=2 last=1 rv=1 rdata=6e",
                     k, l, ok, bus_if.rdata_valid, bus_if.rdata);
        end
        serve_cmd(0, 1'b1, 8'h00, k, b, l, ok, st);
        n_cmp++;
        if (!ok || k !== 2'b01 || bus_if.done !== 1'b1 || bus_if.err_nack !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_done: kind=%0d ok=%0d done=%b err=%b, expected kind=1 done=1 err=0",
                     k, ok, bus_if.done, bus_if.err_nack);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_if.req_valid = 1'b0; bus_if.req_op = 1'b0; bus_if.req_addr = 7'h00; bus_if.req_len = 4'd0;
        bus_if.wdata_valid = 1'b0; bus_if.wdata = 8'h00; bus_if.cmd_ready = 1'b0;
        bus_if.rsp_valid = 1'b0; bus_if.rsp_ack = 1'b0; bus_if.rsp_byte = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_nack();
        test_addr_nack();
        test_trickle();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
